// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported memory bus between I-fetch reads and D loads/stores.
// Latency: grant edge -> mem_req next cycle; mem_ready edge -> *_done next cycle (2 cycles + memory latency).
// Backpressure: mem_req and its fields hold until mem_ready; requesters hold activate until done.
// Build option: MEM_ARB_ROUND_ROBIN_EN alternates I/D on ties; undefined gives fixed D priority.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BYTES_WIDTH = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  // instruction fetch (read only)
  input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
  input  logic                   i_fetch_activate,
  output logic [DATA_WIDTH-1:0]  i_fetched_data,
  output logic                   i_fetch_done,
  // memory stage load
  input  logic [ADDR_WIDTH-1:0]  d_fetch_addr,
  input  logic                   d_fetch_activate,
  output logic [DATA_WIDTH-1:0]  d_fetched_data,
  output logic                   d_fetch_done,
  // memory stage store
  input  logic [ADDR_WIDTH-1:0]  d_write_addr,
  input  logic [DATA_WIDTH-1:0]  d_write_data,
  input  logic [BYTES_WIDTH-1:0] d_bytes_to_write,
  input  logic                   d_write_activate,
  output logic                   d_write_done,
  // memory bus
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic [BYTES_WIDTH-1:0] mem_bytes,
  input  logic                   mem_ready,
  input  logic [DATA_WIDTH-1:0]  mem_rdata
);

  localparam logic [BYTES_WIDTH-1:0] WORD_BYTES = BYTES_WIDTH'(DATA_WIDTH/8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // One bus transaction as presented on mem_*.
  typedef struct packed {
    logic                   we;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [BYTES_WIDTH-1:0] bytes;
  } bus_txn_t;

  state_t   state_q, state_d;
  bus_txn_t txn_q, grant_txn;
  logic     req_q;
  logic     grant_i, grant_d, grant_store;
  logic     bus_done;

  // Per-port completion flags, copies of the granted fields, and read buffers.
  logic                   i_held_q, dl_held_q, ds_held_q;
  logic [ADDR_WIDTH-1:0]  i_cmp_addr_q, dl_cmp_addr_q, ds_cmp_addr_q;
  logic [DATA_WIDTH-1:0]  ds_cmp_wdata_q;
  logic [BYTES_WIDTH-1:0] ds_cmp_bytes_q;
  logic [DATA_WIDTH-1:0]  i_buf_q, dl_buf_q;

  logic i_hold, dl_hold, ds_hold;
  logic i_elig, dl_elig, ds_elig, d_elig;
  logic i_cpl, dl_cpl, ds_cpl;

  // A port stays complete only while it keeps presenting exactly the request that was served;
  // any change or a dropped activate releases it and makes it eligible in the same cycle.
  assign i_hold  = i_held_q && i_fetch_activate && (i_fetch_addr == i_cmp_addr_q);
  assign dl_hold = dl_held_q && d_fetch_activate && (d_fetch_addr == dl_cmp_addr_q);
  assign ds_hold = ds_held_q && d_write_activate &&
                   (d_write_addr == ds_cmp_addr_q) &&
                   (d_write_data == ds_cmp_wdata_q) &&
                   (d_bytes_to_write == ds_cmp_bytes_q);

  assign i_elig  = i_fetch_activate && !i_hold;
  assign dl_elig = d_fetch_activate && !dl_hold;
  assign ds_elig = d_write_activate && !ds_hold;
  assign d_elig  = ds_elig || dl_elig;

  // The bus is only ever busy while mem_req is up, so a stray mem_ready in IDLE is ignored.
  assign bus_done = (state_q != IDLE) && mem_ready;
  assign i_cpl    = bus_done && (state_q == BUSY_I);
  assign dl_cpl   = bus_done && (state_q == BUSY_D) && !txn_q.we;
  assign ds_cpl   = bus_done && (state_q == BUSY_D) && txn_q.we;

  // The store side wins inside D so a store issued ahead of a load completes first.
  assign grant_store = grant_d && ds_elig;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_q;

  // Remember which requester got the bus last; starts at D so I wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d_q <= 1'b1;
    end else if (grant_i) begin
      last_d_q <= 1'b0;
    end else if (grant_d) begin
      last_d_q <= 1'b1;
    end
  end
`endif

  // Bus FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration in IDLE and return to IDLE on completion (which forces one idle cycle between accesses).
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_elig && i_elig) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (last_d_q) begin
            grant_i = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
`else
          grant_d = 1'b1;
`endif
        end else if (d_elig) begin
          grant_d = 1'b1;
        end else if (i_elig) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          state_d = BUSY_D;
        end else if (grant_i) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the fields captured for the bus at grant; reads always request a full word.
  always_comb begin
    grant_txn       = '0;
    grant_txn.bytes = WORD_BYTES;
    if (grant_store) begin
      grant_txn.we    = 1'b1;
      grant_txn.addr  = d_write_addr;
      grant_txn.wdata = d_write_data;
      grant_txn.bytes = d_bytes_to_write;
    end else if (grant_d) begin
      grant_txn.addr  = d_fetch_addr;
    end else begin
      grant_txn.addr  = i_fetch_addr;
    end
  end

  // Bus request and latched transaction; fields stay frozen until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
      txn_q <= '0;
    end else if (grant_i || grant_d) begin
      req_q <= 1'b1;
      txn_q <= grant_txn;
    end else if (bus_done) begin
      req_q <= 1'b0;
    end
  end

  // I port: capture granted address, then hold completion and data until released.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_held_q     <= 1'b0;
      i_cmp_addr_q <= '0;
      i_buf_q      <= '0;
    end else begin
      i_held_q <= i_hold;
      if (grant_i) begin
        i_cmp_addr_q <= i_fetch_addr;
      end
      if (i_cpl) begin
        i_held_q <= 1'b1;
        i_buf_q  <= mem_rdata;
      end
    end
  end

  // D load port: same hold scheme as I.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_held_q     <= 1'b0;
      dl_cmp_addr_q <= '0;
      dl_buf_q      <= '0;
    end else begin
      dl_held_q <= dl_hold;
      if (grant_d && !grant_store) begin
        dl_cmp_addr_q <= d_fetch_addr;
      end
      if (dl_cpl) begin
        dl_held_q <= 1'b1;
        dl_buf_q  <= mem_rdata;
      end
    end
  end

  // D store port: completion is held against address, data and size.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_held_q      <= 1'b0;
      ds_cmp_addr_q  <= '0;
      ds_cmp_wdata_q <= '0;
      ds_cmp_bytes_q <= '0;
    end else begin
      ds_held_q <= ds_hold;
      if (grant_store) begin
        ds_cmp_addr_q  <= d_write_addr;
        ds_cmp_wdata_q <= d_write_data;
        ds_cmp_bytes_q <= d_bytes_to_write;
      end
      if (ds_cpl) begin
        ds_held_q <= 1'b1;
      end
    end
  end

  assign i_fetch_done   = i_hold;
  assign i_fetched_data = i_buf_q;
  assign d_fetch_done   = dl_hold;
  assign d_fetched_data = dl_buf_q;
  assign d_write_done   = ds_hold;

  assign mem_req   = req_q;
  assign mem_we    = txn_q.we;
  assign mem_addr  = txn_q.addr;
  assign mem_wdata = txn_q.wdata;
  assign mem_bytes = txn_q.bytes;

endmodule
